sparse_weight_encoder: RTL and testbench

- Producer end of the PE weight bundle: converts a dense weight stream for one filter slice (fixed s) into the compressed format the PE consumes.
- Output 1 is a value stream of nonzero weights, each with its channel index (w_data / w_c_idx).
- Output 2 is a row stream with one record per nonempty (k,r) row (pos_ptr / r_idx / k_idx).
- Sits between the weight loader and the PE weight buffers.

---
 rtl/sparse_weight_encoder.sv | 181 ++++++++++++++++++
 tb/tb_sparse_weight_encoder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_weight_encoder.sv
// Dense-to-sparse weight encoder: turns one filter slice of dense weights into a
// nonzero value stream plus a per-(k,r) row stream of start pointers.
module sparse_weight_encoder #(
  parameter int DATA_W   = 16,
  parameter int C_W      = 5,
  parameter int R_W      = 2,
  parameter int K_W      = 5,
  parameter int PTR_W    = 11,
  parameter int MAX_ROWS = 48
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [C_W:0]      i_num_c,
  input  logic [R_W-1:0]    i_num_r,
  input  logic [K_W:0]      i_num_k,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_v_valid,
  input  logic              i_v_ready,
  output logic [DATA_W-1:0] o_w_data,
  output logic [C_W-1:0]    o_w_c_idx,
  output logic              o_row_valid,
  input  logic              i_row_ready,
  output logic [PTR_W-1:0]  o_pos_ptr,
  output logic [R_W-1:0]    o_r_idx,
  output logic [K_W-1:0]    o_k_idx,
  output logic [PTR_W:0]    o_nnz,
  output logic [6:0]        o_nrows,
  output logic              o_overflow,
  output logic              o_finish
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [PTR_W:0] NNZ_MAX  = (PTR_W+1)'((1 << PTR_W) - 1);
  localparam logic [6:0]     ROWS_MAX = 7'(MAX_ROWS);

  state_t           state;
  logic [C_W:0]     num_c;
  logic [R_W-1:0]   num_r;
  logic [K_W:0]     num_k;
  logic [C_W-1:0]   c_cnt;
  logic [R_W-1:0]   r_cnt;
  logic [K_W-1:0]   k_cnt;
  logic [PTR_W:0]   nnz;
  logic [PTR_W-1:0] row_start;
  logic [6:0]       nrows;
  logic             row_nz;

  logic             v_free, row_free, accept, beat_nz;
  logic             last_c, last_r, last_k;
  logic             val_keep, row_emit, row_keep;
  logic [PTR_W:0]   nnz_next;

  always_comb begin
    v_free   = !o_v_valid || i_v_ready;
    row_free = !o_row_valid || i_row_ready;
    o_ready  = (state == RUN) && v_free && row_free;
    accept   = i_valid && o_ready;
    beat_nz  = |i_data;
    last_c   = {1'b0, c_cnt} == (num_c - (C_W+1)'(1));
    last_r   = r_cnt == (num_r - R_W'(1));
    last_k   = {1'b0, k_cnt} == (num_k - (K_W+1)'(1));
    // A nonzero beat is dropped once the value stream is full; the row still counts it.
    val_keep = beat_nz && (nnz < NNZ_MAX);
    nnz_next = nnz + (PTR_W+1)'(val_keep);
    row_emit = last_c && (row_nz || beat_nz);
    row_keep = row_emit && (nrows < ROWS_MAX);
  end

  assign o_nnz   = nnz;
  assign o_nrows = nrows;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      num_c       <= '0;
      num_r       <= '0;
      num_k       <= '0;
      c_cnt       <= '0;
      r_cnt       <= '0;
      k_cnt       <= '0;
      nnz         <= '0;
      row_start   <= '0;
      nrows       <= '0;
      row_nz      <= 1'b0;
      o_v_valid   <= 1'b0;
      o_w_data    <= '0;
      o_w_c_idx   <= '0;
      o_row_valid <= 1'b0;
      o_pos_ptr   <= '0;
      o_r_idx     <= '0;
      o_k_idx     <= '0;
      o_overflow  <= 1'b0;
      o_finish    <= 1'b0;
    end else begin
      // NOTE: handshake clears come first; a reload later in this block wins
      // because the last non-blocking assignment to a register takes effect.
      if (i_v_ready)   o_v_valid   <= 1'b0;
      if (i_row_ready) o_row_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (i_start) begin
            num_c      <= i_num_c;
            num_r      <= i_num_r;
            num_k      <= i_num_k;
            c_cnt      <= '0;
            r_cnt      <= '0;
            k_cnt      <= '0;
            nnz        <= '0;
            row_start  <= '0;
            nrows      <= '0;
            row_nz     <= 1'b0;
            o_overflow <= 1'b0;
            state      <= RUN;
          end
        end

        RUN: begin
          if (accept) begin
            if (val_keep) begin
              o_v_valid <= 1'b1;
              o_w_data  <= i_data;
              o_w_c_idx <= c_cnt;
            end else if (beat_nz) begin
              o_overflow <= 1'b1;
            end
            nnz <= nnz_next;

            if (row_keep) begin
              o_row_valid <= 1'b1;
              o_pos_ptr   <= row_start;
              o_r_idx     <= r_cnt;
              o_k_idx     <= k_cnt;
              nrows       <= nrows + 7'd1;
            end else if (row_emit) begin
              o_overflow <= 1'b1;
            end

            if (last_c) begin
              row_start <= nnz_next[PTR_W-1:0];
              row_nz    <= 1'b0;
              c_cnt     <= '0;
              if (last_r) begin
                r_cnt <= '0;
                if (!last_k) k_cnt <= k_cnt + K_W'(1);
              end else begin
                r_cnt <= r_cnt + R_W'(1);
              end
              if (last_r && last_k) state <= FLUSH;
            end else begin
              c_cnt <= c_cnt + C_W'(1);
              if (beat_nz) row_nz <= 1'b1;
            end
          end
        end

        FLUSH: begin
          if (v_free && row_free) begin
            o_finish <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          // Holding i_start high parks here; only its release returns to IDLE.
          if (!i_start) begin
            o_finish <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_weight_encoder.sv
// Self-checking bench for sparse_weight_encoder: table of passes, scoreboard
// queues for the value and row streams, plus reset and held-start sequences.
module tb_sparse_weight_encoder;

  localparam int DATA_W   = 16;
  localparam int C_W      = 5;
  localparam int R_W      = 2;
  localparam int K_W      = 5;
  localparam int PTR_W    = 11;
  localparam int MAX_ROWS = 48;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic [C_W:0]      i_num_c;
  logic [R_W-1:0]    i_num_r;
  logic [K_W:0]      i_num_k;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_v_valid;
  logic              i_v_ready;
  logic [DATA_W-1:0] o_w_data;
  logic [C_W-1:0]    o_w_c_idx;
  logic              o_row_valid;
  logic              i_row_ready;
  logic [PTR_W-1:0]  o_pos_ptr;
  logic [R_W-1:0]    o_r_idx;
  logic [K_W-1:0]    o_k_idx;
  logic [PTR_W:0]    o_nnz;
  logic [6:0]        o_nrows;
  logic              o_overflow;
  logic              o_finish;

  sparse_weight_encoder #(
    .DATA_W(DATA_W), .C_W(C_W), .R_W(R_W), .K_W(K_W), .PTR_W(PTR_W), .MAX_ROWS(MAX_ROWS)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_num_c(i_num_c), .i_num_r(i_num_r), .i_num_k(i_num_k),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_v_valid(o_v_valid), .i_v_ready(i_v_ready),
    .o_w_data(o_w_data), .o_w_c_idx(o_w_c_idx),
    .o_row_valid(o_row_valid), .i_row_ready(i_row_ready),
    .o_pos_ptr(o_pos_ptr), .o_r_idx(o_r_idx), .o_k_idx(o_k_idx),
    .o_nnz(o_nnz), .o_nrows(o_nrows), .o_overflow(o_overflow), .o_finish(o_finish)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [C_W-1:0]    c;
  } val_rec_t;

  typedef struct {
    logic [PTR_W-1:0] ptr;
    logic [R_W-1:0]   r;
    logic [K_W-1:0]   k;
  } row_rec_t;

  typedef struct {
    int num_c;
    int num_r;
    int num_k;
    int pat;
    int bp;
    int exp_nnz;
    int exp_nrows;
    int exp_ovf;
  } vec_t;

  val_rec_t          vq[$];
  row_rec_t          rq[$];
  vec_t              vecs[4];
  logic [DATA_W-1:0] pat0[4];
  logic [DATA_W-1:0] pat1[12];

  int checks = 0;
  int errors = 0;

  // Reference state for the scoreboard, stepped once per accepted beat.
  int m_num_c, m_num_r, m_c, m_r, m_k, m_nnz, m_row_start, m_row_nz, m_nrows;

  int   cyc = 0;
  int   bp_mode = 0;
  int   bp_start = 0;
  logic acc = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] get_data(input int pat, input int idx);
    if (pat == 0) return pat0[idx];
    if (pat == 1) return pat1[idx];
    return DATA_W'(1);
  endfunction

  task automatic model_beat(input logic [DATA_W-1:0] d);
    val_rec_t ve;
    row_rec_t re;
    int nz;
    nz = (d != '0) ? 1 : 0;
    if (nz != 0 && m_nnz < (1 << PTR_W) - 1) begin
      ve.data = d;
      ve.c    = C_W'(m_c);
      vq.push_back(ve);
      m_nnz++;
    end
    if (m_c == m_num_c - 1) begin
      if ((m_row_nz != 0 || nz != 0) && m_nrows < MAX_ROWS) begin
        re.ptr = PTR_W'(m_row_start);
        re.r   = R_W'(m_r);
        re.k   = K_W'(m_k);
        rq.push_back(re);
        m_nrows++;
      end
      m_row_start = m_nnz;
      m_row_nz    = 0;
      m_c         = 0;
      if (m_r == m_num_r - 1) begin
        m_r = 0;
        m_k++;
      end else begin
        m_r++;
      end
    end else begin
      m_c++;
      if (nz != 0) m_row_nz = 1;
    end
  endtask

  // Sink readiness: always ready, or v_ready toggling with a 5-cycle row stall.
  int rel;
  initial begin
    i_v_ready   = 1'b1;
    i_row_ready = 1'b1;
    forever begin
      @(negedge i_clk);
      cyc++;
      rel = cyc - bp_start;
      if (bp_mode == 1) begin
        i_v_ready   = rel[0];
        i_row_ready = !(rel >= 4 && rel < 9);
      end else begin
        i_v_ready   = 1'b1;
        i_row_ready = 1'b1;
      end
    end
  end

  // Monitor: samples mid-cycle, ahead of the edge where handshakes complete.
  val_rec_t ev;
  row_rec_t er;
  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      acc = i_valid & o_ready;
      if (o_v_valid && i_v_ready) begin
        if (vq.size() == 0) begin
          check("val_unexpected", 64'd1, 64'd0);
        end else begin
          ev = vq.pop_front();
          check("val_data", 64'(o_w_data), 64'(ev.data));
          check("val_c_idx", 64'(o_w_c_idx), 64'(ev.c));
        end
      end
      if (o_row_valid && i_row_ready) begin
        if (rq.size() == 0) begin
          check("row_unexpected", 64'd1, 64'd0);
        end else begin
          er = rq.pop_front();
          check("row_ptr", 64'(o_pos_ptr), 64'(er.ptr));
          check("row_r", 64'(o_r_idx), 64'(er.r));
          check("row_k", 64'(o_k_idx), 64'(er.k));
        end
      end
      if ((o_v_valid && !i_v_ready) || (o_row_valid && !i_row_ready))
        check("ready_when_blocked", 64'(o_ready), 64'd0);
    end
  end

  task automatic start_pass(input int v, input bit hold);
    @(negedge i_clk);
    i_num_c  = (C_W+1)'(vecs[v].num_c);
    i_num_r  = R_W'(vecs[v].num_r);
    i_num_k  = (K_W+1)'(vecs[v].num_k);
    i_start  = 1'b1;
    bp_mode  = vecs[v].bp;
    bp_start = cyc;
    m_num_c = vecs[v].num_c;
    m_num_r = vecs[v].num_r;
    m_c = 0; m_r = 0; m_k = 0;
    m_nnz = 0; m_row_start = 0; m_row_nz = 0; m_nrows = 0;
    @(negedge i_clk);
    if (!hold) i_start = 1'b0;
  endtask

  task automatic drive_beats(input int v, input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = get_data(vecs[v].pat, i);
      do begin
        @(posedge i_clk);
        guard++;
      end while (!acc && guard < 100);
      if (!acc) begin
        check("beat_accept_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
        return;
      end
      model_beat(i_data);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic finish_pass(input int v, input bit hold);
    int guard;
    guard = 0;
    #2;
    while (!o_finish && guard < 500) begin
      @(negedge i_clk);
      #2;
      guard++;
    end
    check("finish", 64'(o_finish), 64'd1);
    check("nnz", 64'(o_nnz), 64'(vecs[v].exp_nnz));
    check("nrows", 64'(o_nrows), 64'(vecs[v].exp_nrows));
    check("overflow", 64'(o_overflow), 64'(vecs[v].exp_ovf));
    check("val_queue_drained", 64'(vq.size()), 64'd0);
    check("row_queue_drained", 64'(rq.size()), 64'd0);
    if (hold) begin
      repeat (4) begin
        @(negedge i_clk);
        #2;
        check("finish_held", 64'(o_finish), 64'd1);
        check("no_restart_ready", 64'(o_ready), 64'd0);
        check("no_restart_nnz", 64'(o_nnz), 64'(vecs[v].exp_nnz));
      end
      @(negedge i_clk);
      i_start = 1'b0;
    end
    @(negedge i_clk);
    #2;
    check("finish_clear", 64'(o_finish), 64'd0);
  endtask

  task automatic run_vec(input int v, input bit hold);
    start_pass(v, hold);
    drive_beats(v, vecs[v].num_c * vecs[v].num_r * vecs[v].num_k);
    finish_pass(v, hold);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(o_ready), 64'd0);
    check({tag, "_v_valid"}, 64'(o_v_valid), 64'd0);
    check({tag, "_row_valid"}, 64'(o_row_valid), 64'd0);
    check({tag, "_w_data"}, 64'(o_w_data), 64'd0);
    check({tag, "_pos_ptr"}, 64'(o_pos_ptr), 64'd0);
    check({tag, "_nnz"}, 64'(o_nnz), 64'd0);
    check({tag, "_nrows"}, 64'(o_nrows), 64'd0);
    check({tag, "_overflow"}, 64'(o_overflow), 64'd0);
    check({tag, "_finish"}, 64'(o_finish), 64'd0);
  endtask

  initial begin
    pat0 = '{16'd0, 16'd5, 16'd0, 16'hFFFD};
    pat1 = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0};
    //            c   r   k  pat bp  nnz  rows ovf
    vecs[0] = '{  4,  1,  1,  0, 0,    2,   1, 0};
    vecs[1] = '{  2,  3,  2,  1, 0,    4,   3, 0};
    vecs[2] = '{  2,  3,  2,  1, 1,    4,   3, 0};
    vecs[3] = '{ 32,  3, 32,  2, 0, 2047,  48, 1};

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_num_c = '0;
    i_num_r = '0;
    i_num_k = '0;
    repeat (3) @(negedge i_clk);
    #2;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int v = 0; v < 4; v++) run_vec(v, 1'b0);

    // Reset mid-pass with records in flight, then a clean rerun of the same pass.
    start_pass(1, 1'b0);
    drive_beats(1, 7);
    i_rst = 1'b1;
    @(negedge i_clk);
    #2;
    check_all_zero("midreset");
    i_rst = 1'b0;
    vq.delete();
    rq.delete();
    run_vec(1, 1'b0);

    // i_start held high through DONE must not restart the pass.
    run_vec(0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
